// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit:
// FSM encoding, operation select and iteration count.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int ITER = 32;

endpackage

// File: rtl/mult_div_unit_div_core.sv
// Unsigned restoring divider on operand magnitudes.
// One quotient bit per step; sign fix-up lives in the top.
module mult_div_unit_div_core (
  input  logic        clk,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  import mult_div_unit_pkg::*;

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dsr_q;
  logic [32:0] shifted;
  logic [32:0] diff;

  // rem < divisor <= 2^31, so shifted never exceeds 32 bits
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dsr_q};
  end

  always_ff @(posedge clk) begin
    if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
    end else if (step) begin
      if (!diff[32]) begin
        rem_q <= diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= shifted[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide unit
// owning the architectural HI and LO registers.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  import mult_div_unit_pkg::*;

  localparam logic [4:0] LAST = 5'(ITER - 1);

  state_t      state;
  state_t      next;
  logic        op;
  logic        dz;
  logic        sgn_q;
  logic        sgn_r;
  logic [4:0]  cnt;
  logic [64:0] prod;
  logic [31:0] mcand;
  logic [32:0] bsum;
  logic [64:0] bnext;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        div_load;
  logic        div_step;

  assign busy     = (state != IDLE);
  assign abs_a    = inputA[31] ? -inputA : inputA;
  assign abs_b    = inputB[31] ? -inputB : inputB;
  assign div_load = (state == IDLE) && !start_mult && start_div;
  assign div_step = (state == DIV);

  mult_div_unit_div_core u_div (
    .clk       (clk),
    .load      (div_load),
    .step      (div_step),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quo),
    .remainder (rem)
  );

  // 33-bit sum keeps the most-negative multiplicand exact
  always_comb begin
    bsum = {prod[64], prod[64:33]};
    unique case (prod[1:0])
      2'b10:   bsum = bsum - {mcand[31], mcand};
      2'b01:   bsum = bsum + {mcand[31], mcand};
      default: bsum = {prod[64], prod[64:33]};
    endcase
    bnext = {bsum, prod[32:1]};
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (start_mult)
          next = MULT;
        else if (start_div)
          next = (inputB == '0) ? FINISH : DIV;
      end
      MULT, DIV: begin
        if (cnt == LAST)
          next = FINISH;
      end
      FINISH:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_out   <= '0;
      lo_out   <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      prod     <= '0;
      mcand    <= '0;
      op       <= OP_MULT;
      dz       <= 1'b0;
      sgn_q    <= 1'b0;
      sgn_r    <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (start_mult) begin
            op    <= OP_MULT;
            dz    <= 1'b0;
            mcand <= inputA;
            prod  <= {32'b0, inputB, 1'b0};
          end else if (start_div) begin
            op    <= OP_DIV;
            dz    <= (inputB == '0);
            sgn_q <= inputA[31] ^ inputB[31];
            sgn_r <= inputA[31];
          end
        end
        MULT: begin
          prod <= bnext;
          cnt  <= cnt + 5'd1;
        end
        DIV: cnt <= cnt + 5'd1;
        FINISH: begin
          done <= 1'b1;
          if (dz) begin
            div_zero <= 1'b1;
          end else if (op == OP_MULT) begin
            hi_out <= prod[64:33];
            lo_out <= prod[32:1];
          end else begin
            lo_out <= sgn_q ? -quo : quo;
            hi_out <= sgn_r ? -rem : rem;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases
// plus randomized ops against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] inputA = '0;
  logic [31:0] inputB = '0;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .inputA     (inputA),
    .inputB     (inputB),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  // reference: signed 64-bit arithmetic, C-style truncating divide
  task automatic model(input bit mul, input logic [31:0] a,
                       input logic [31:0] b,
                       output logic edz, output int elat);
    logic [63:0] p;
    longint sa;
    longint sb;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    edz  = 1'b0;
    elat = 33;
    if (mul) begin
      p    = 64'(sa * sb);
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (b == 32'd0) begin
      edz  = 1'b1;
      elat = 1;
    end else begin
      p    = 64'(sa / sb);
      m_lo = p[31:0];
      p    = 64'(sa % sb);
      m_hi = p[31:0];
    end
  endtask

  task automatic do_op(input logic sm, input logic sd,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l,
                       output logic dz, output int lat,
                       output int bcnt, output logic bdone);
    @(negedge clk);
    start_mult = sm;
    start_div  = sd;
    inputA     = a;
    inputB     = b;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    inputA     = $urandom;
    inputB     = $urandom;
    lat   = -1;
    bcnt  = 0;
    h     = 'x;
    l     = 'x;
    dz    = 1'bx;
    bdone = 1'bx;
    for (int k = 1; k <= 100; k++) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat   = k;
        h     = hi_out;
        l     = lo_out;
        dz    = div_zero;
        bdone = busy;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (hi_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_hi: got %h expected 0", hi_out);
    end
    n_tests++;
    if (lo_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_lo: got %h expected 0", lo_out);
    end
    n_tests++;
    if ({busy, done, div_zero} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000",
               {busy, done, div_zero});
    end
    reset = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
  endtask

  logic [31:0] dir_a [6] = '{32'h00000007, 32'h80000000, 32'hFFFFFFFF,
                             32'hFFFFFFF9, 32'h00000007, 32'h80000000};
  logic [31:0] dir_b [6] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF,
                             32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF};
  logic [31:0] dir_h [6] = '{32'hFFFFFFFF, 32'h40000000, 32'h00000000,
                             32'hFFFFFFFF, 32'h00000001, 32'h00000000};
  logic [31:0] dir_l [6] = '{32'hFFFFFFEB, 32'h00000000, 32'h00000001,
                             32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000};

  task automatic test_directed;
    logic [31:0] h, l;
    logic        dz, bd;
    int          lat, bc;
    for (int i = 0; i < 6; i++) begin
      do_op(i < 3, i >= 3, dir_a[i], dir_b[i], h, l, dz, lat, bc, bd);
      n_tests++;
      if (h !== dir_h[i] || l !== dir_l[i] || dz !== 1'b0) begin
        n_fail++;
        $display("FAIL directed[%0d]: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=0",
                 i, h, l, dz, dir_h[i], dir_l[i]);
      end
      n_tests++;
      if (lat !== 33 || bc !== 33 || bd !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_timing[%0d]: got lat=%0d busy_cycles=%0d busy_at_done=%b expected 33 33 0",
                 i, lat, bc, bd);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL done_pulse[%0d]: got %b expected 0", i, done);
      end
      m_hi = dir_h[i];
      m_lo = dir_l[i];
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] h, l;
    logic        dz, bd, edz;
    int          lat, bc, elat;
    model(1'b0, 32'h451, 32'h20, edz, elat);
    do_op(1'b0, 1'b1, 32'h451, 32'h20, h, l, dz, lat, bc, bd);
    n_tests++;
    if (h !== 32'h11 || l !== 32'h22) begin
      n_fail++;
      $display("FAIL dz_preload: got hi=%h lo=%h expected 11 22", h, l);
    end
    model(1'b0, 32'd5, 32'd0, edz, elat);
    do_op(1'b0, 1'b1, 32'd5, 32'd0, h, l, dz, lat, bc, bd);
    n_tests++;
    if (lat !== 1 || dz !== 1'b1 || bc !== 1) begin
      n_fail++;
      $display("FAIL dz_flag: got lat=%0d dz=%b busy_cycles=%0d expected 1 1 1",
               lat, dz, bc);
    end
    n_tests++;
    if (h !== 32'h11 || l !== 32'h22) begin
      n_fail++;
      $display("FAIL dz_hold: got hi=%h lo=%h expected 11 22", h, l);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, div_zero} !== 3'b000) begin
      n_fail++;
      $display("FAIL dz_idle: got %b expected 000", {busy, done, div_zero});
    end
  endtask

  task automatic test_start_ignored;
    logic [31:0] h, l;
    logic        dz, bd, edz;
    int          lat, bc, elat, ndone, first;
    model(1'b1, 32'h00012345, 32'hFFFF0007, edz, elat);
    @(negedge clk);
    start_mult = 1'b1;
    inputA     = 32'h00012345;
    inputB     = 32'hFFFF0007;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    ndone = 0;
    first = -1;
    h = 'x;
    l = 'x;
    for (int k = 1; k <= 45; k++) begin
      start_div = (k == 5);
      inputA    = 32'd99;
      inputB    = 32'd3;
      @(posedge clk);
      #1;
      start_div = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) begin
          first = k;
          h = hi_out;
          l = lo_out;
        end
      end
    end
    n_tests++;
    if (ndone !== 1 || first !== 33) begin
      n_fail++;
      $display("FAIL busy_start: got dones=%0d first=%0d expected 1 33",
               ndone, first);
    end
    n_tests++;
    if (h !== m_hi || l !== m_lo) begin
      n_fail++;
      $display("FAIL busy_start_res: got hi=%h lo=%h expected hi=%h lo=%h",
               h, l, m_hi, m_lo);
    end
    model(1'b1, 32'hFFFFFF00, 32'h00000300, edz, elat);
    do_op(1'b1, 1'b1, 32'hFFFFFF00, 32'h00000300, h, l, dz, lat, bc, bd);
    n_tests++;
    if (h !== m_hi || l !== m_lo || lat !== 33 || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL both_starts: got hi=%h lo=%h lat=%0d dz=%b expected hi=%h lo=%h lat=33 dz=0",
               h, l, lat, dz, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] h, l;
    logic        dz, bd, edz;
    int          lat, bc, elat, ndone;
    @(negedge clk);
    start_div = 1'b1;
    inputA    = 32'd100;
    inputB    = 32'd7;
    @(posedge clk);
    #1;
    start_div = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
    n_tests++;
    if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_state: got busy=%b hi=%h lo=%h expected 0 0 0",
               busy, hi_out, lo_out);
    end
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) ndone++;
    end
    n_tests++;
    if (ndone !== 0) begin
      n_fail++;
      $display("FAIL abort_done: got %0d done cycles expected 0", ndone);
    end
    model(1'b1, 32'd3, 32'd4, edz, elat);
    do_op(1'b1, 1'b0, 32'd3, 32'd4, h, l, dz, lat, bc, bd);
    n_tests++;
    if (h !== 32'd0 || l !== 32'd12 || lat !== 33) begin
      n_fail++;
      $display("FAIL abort_recover: got hi=%h lo=%h lat=%0d expected 0 c 33",
               h, l, lat);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, h, l;
    logic        dz, bd, edz;
    int          lat, bc, elat;
    bit          mul;
    for (int i = 0; i < 30; i++) begin
      mul = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h80000000;
        2: b = 32'hFFFFFFFF;
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      model(mul, a, b, edz, elat);
      do_op(mul, !mul, a, b, h, l, dz, lat, bc, bd);
      n_tests++;
      if (h !== m_hi || l !== m_lo || dz !== edz || lat !== elat) begin
        n_fail++;
        $display("FAIL random[%0d] mul=%b a=%h b=%h: got hi=%h lo=%h dz=%b lat=%0d expected hi=%h lo=%h dz=%b lat=%0d",
                 i, mul, a, b, h, l, dz, lat, m_hi, m_lo, edz, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_start_ignored();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
